postcode: RTL and testbench

POSTCODE -- requirements
Module: postcode

---
 rtl/postcode.sv | 166 ++++++++++++++++
 tb/tb_postcode.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/postcode.sv
// POST-code style serial link: pulse groups on testreq carry rx bits (1/2 pulses) or tx reads (3+).
// Optional build macro POSTCODE_GLITCH_FILTER_EN adds a 3-sample agreement filter after the synchronizer.
module postcode #(
    parameter int GAP_CYCLES = 96
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       testreq,
    output logic       testack,
    output logic [7:0] rxout,
    output logic       rxfull,
    input  logic       rxreset,
    input  logic [7:0] txin,
    output logic       txempty,
    input  logic       txstart
);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYCLES);

    logic          sync1_q, sync2_q, lvl_prev_q;
    logic          lvl, rise;
    logic [1:0]    pcnt_q, pcnt_d, pcnt_inc;
    logic [GW-1:0] gap_q, gap_d;
    logic          gap_close;
    logic [7:0]    rx_sr_q, rx_sr_d;
    logic [3:0]    rx_cnt_q, rx_cnt_d;
    logic [7:0]    rxout_q, rxout_d;
    logic          rxfull_q, rxfull_d;
    logic [7:0]    tx_sr_q, tx_sr_d;
    logic [3:0]    tx_cnt_q, tx_cnt_d;
    logic          txempty_q, txempty_d;
    logic          testack_q, testack_d;

`ifdef POSTCODE_GLITCH_FILTER_EN
    // Level only moves once three consecutive synchronized samples agree.
    logic hist1_q, hist2_q, filt_q;

    always_comb begin
        lvl = filt_q;
        if (sync2_q && hist1_q && hist2_q)
            lvl = 1'b1;
        else if (!sync2_q && !hist1_q && !hist2_q)
            lvl = 1'b0;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
            filt_q  <= lvl;
        end
    end
`else
    assign lvl = sync2_q;
`endif

    assign rise      = lvl & ~lvl_prev_q;
    assign pcnt_inc  = (pcnt_q == 2'd3) ? 2'd3 : pcnt_q + 2'd1;
    // A group closes on the GAP_CYCLES-th consecutive low cycle.
    assign gap_close = ~lvl && (gap_q == GAP_LAST) && (pcnt_q != 2'd0);

    always_comb begin
        pcnt_d = pcnt_q;
        if (rise)
            pcnt_d = pcnt_inc;
        else if (gap_close)
            pcnt_d = 2'd0;

        gap_d = gap_q;
        if (lvl)
            gap_d = '0;
        else if (gap_q != GAP_MAX)
            gap_d = gap_q + 1'b1;

        testack_d = 1'b0;
        if (lvl) begin
            case (pcnt_d)
                2'd1:    testack_d = 1'b1;
                2'd2:    testack_d = ~txempty_q;
                2'd3:    testack_d = ~txempty_q & tx_sr_q[7];
                default: testack_d = 1'b0;
            endcase
        end
    end

    // Receive path: completed byte is handed to rxout one cycle after the closing group.
    always_comb begin
        rx_sr_d  = rx_sr_q;
        rx_cnt_d = rx_cnt_q;
        rxout_d  = rxout_q;
        rxfull_d = rxfull_q & ~rxreset;
        if (rx_cnt_q == 4'd8) begin
            rx_cnt_d = 4'd0;
            if (!rxfull_q || rxreset) begin
                rxout_d  = rx_sr_q;
                rxfull_d = 1'b1;
            end
        end else if (gap_close && pcnt_q != 2'd3) begin
            rx_sr_d  = {rx_sr_q[6:0], pcnt_q == 2'd2};
            rx_cnt_d = rx_cnt_q + 4'd1;
        end
    end

    // Transmit path: each read group consumes the MSB; register frees after eight reads.
    always_comb begin
        tx_sr_d   = tx_sr_q;
        tx_cnt_d  = tx_cnt_q;
        txempty_d = txempty_q;
        if (txempty_q) begin
            if (txstart) begin
                tx_sr_d   = txin;
                tx_cnt_d  = 4'd0;
                txempty_d = 1'b0;
            end
        end else if (tx_cnt_q == 4'd8) begin
            tx_cnt_d  = 4'd0;
            txempty_d = 1'b1;
        end else if (gap_close && pcnt_q == 2'd3) begin
            tx_sr_d  = {tx_sr_q[6:0], 1'b0};
            tx_cnt_d = tx_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            lvl_prev_q <= 1'b0;
            pcnt_q     <= 2'd0;
            gap_q      <= '0;
            rx_sr_q    <= 8'h00;
            rx_cnt_q   <= 4'd0;
            rxout_q    <= 8'h00;
            rxfull_q   <= 1'b0;
            tx_sr_q    <= 8'h00;
            tx_cnt_q   <= 4'd0;
            txempty_q  <= 1'b1;
            testack_q  <= 1'b0;
        end else begin
            sync1_q    <= testreq;
            sync2_q    <= sync1_q;
            lvl_prev_q <= lvl;
            pcnt_q     <= pcnt_d;
            gap_q      <= gap_d;
            rx_sr_q    <= rx_sr_d;
            rx_cnt_q   <= rx_cnt_d;
            rxout_q    <= rxout_d;
            rxfull_q   <= rxfull_d;
            tx_sr_q    <= tx_sr_d;
            tx_cnt_q   <= tx_cnt_d;
            txempty_q  <= txempty_d;
            testack_q  <= testack_d;
        end
    end

    assign testack = testack_q;
    assign rxout   = rxout_q;
    assign rxfull  = rxfull_q;
    assign txempty = txempty_q;

endmodule

// File: tb/tb_postcode.sv
// Directed bench for postcode: byte receive, overrun, rxreset, tx reads, reset mid-byte, gap boundary.
module tb_postcode;
    localparam int GAP = 96;

    logic       refclk  = 1'b0;
    logic       rst_n   = 1'b0;
    logic       testreq = 1'b0;
    logic       rxreset = 1'b0;
    logic       txstart = 1'b0;
    logic [7:0] txin    = 8'h00;
    logic       testack, rxfull, txempty;
    logic [7:0] rxout;

    int n_assert = 0;
    int n_fail   = 0;

    postcode #(.GAP_CYCLES(GAP)) dut (
        .refclk  (refclk),
        .rst_n   (rst_n),
        .testreq (testreq),
        .testack (testack),
        .rxout   (rxout),
        .rxfull  (rxfull),
        .rxreset (rxreset),
        .txin    (txin),
        .txempty (txempty),
        .txstart (txstart)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pulse: 8 cycles high then low_cycles low; ack is 0 two cycles in, valid on the third.
    task automatic pulse(input string tag, input logic exp_ack, input int low_cycles);
        testreq = 1'b1;
        repeat (2) @(negedge refclk);
        chk({tag, "/ack_early"}, {31'd0, testack}, 32'd0);
        @(negedge refclk);
        chk({tag, "/ack"}, {31'd0, testack}, {31'd0, exp_ack});
        repeat (5) @(negedge refclk);
        testreq = 1'b0;
        repeat (low_cycles) @(negedge refclk);
    endtask

    task automatic group(input string tag, input int n, input logic e2, input logic e3,
                         input int last_low);
        for (int p = 1; p <= n; p++)
            pulse(tag, (p == 1) ? 1'b1 : ((p == 2) ? e2 : e3), (p == n) ? last_low : 8);
    endtask

    // Sends a byte MSB first with txempty=1 (2nd-pulse ack 0); checks the rxfull edge exactly.
    task automatic send_byte(input string tag, input logic [7:0] b, input logic pre_full,
                             input logic [7:0] exp_out);
        for (int i = 7; i >= 0; i--) begin
            if (i > 0) begin
                group(tag, b[i] ? 2 : 1, 1'b0, 1'b0, 208);
            end else begin
                group(tag, b[i] ? 2 : 1, 1'b0, 1'b0, GAP + 2);
                chk({tag, "/full_pre"}, {31'd0, rxfull}, {31'd0, pre_full});
                @(negedge refclk);
                chk({tag, "/full"}, {31'd0, rxfull}, 32'd1);
                chk({tag, "/rxout"}, {24'd0, rxout}, {24'd0, exp_out});
                repeat (110) @(negedge refclk);
            end
        end
    endtask

    initial begin
        logic [7:0] txb;

        // Reset, with strobes asserted while in reset
        txin    = 8'hFF;
        txstart = 1'b1;
        rxreset = 1'b1;
        repeat (3) @(negedge refclk);
        chk("rst/testack", {31'd0, testack}, 32'd0);
        chk("rst/rxout",   {24'd0, rxout},   32'h00);
        chk("rst/rxfull",  {31'd0, rxfull},  32'd0);
        chk("rst/txempty", {31'd0, txempty}, 32'd1);
        txstart = 1'b0;
        rxreset = 1'b0;
        rst_n   = 1'b1;
        repeat (3) @(negedge refclk);
        chk("rst/txempty_post", {31'd0, txempty}, 32'd1);

        // Receive 0xA5
        send_byte("rxA5", 8'hA5, 1'b0, 8'hA5);

        // Overrun: 0x3C discarded while full
        send_byte("rx3C_ovr", 8'h3C, 1'b1, 8'hA5);
        rxreset = 1'b1;
        @(negedge refclk);
        rxreset = 1'b0;
        chk("rxreset/full",  {31'd0, rxfull}, 32'd0);
        chk("rxreset/rxout", {24'd0, rxout},  32'hA5);
        send_byte("rx3C", 8'h3C, 1'b0, 8'h3C);

        // Transmit 0x81 via eight read groups; second txstart must be ignored
        txin    = 8'h81;
        txstart = 1'b1;
        @(negedge refclk);
        txstart = 1'b0;
        chk("tx/load_empty", {31'd0, txempty}, 32'd0);
        txb = 8'h81;
        for (int g = 0; g < 8; g++) begin
            if (g < 7) begin
                group("tx_rd", 3, 1'b1, txb[7 - g], 208);
            end else begin
                group("tx_rd", 3, 1'b1, txb[7 - g], GAP + 2);
                chk("tx/empty_pre", {31'd0, txempty}, 32'd0);
                @(negedge refclk);
                chk("tx/empty_done", {31'd0, txempty}, 32'd1);
                repeat (110) @(negedge refclk);
            end
            if (g == 0) begin
                txin    = 8'h00;
                txstart = 1'b1;
                @(negedge refclk);
                txstart = 1'b0;
                chk("tx/ignored_start", {31'd0, txempty}, 32'd0);
            end
        end
        chk("tx/rx_untouched", {24'd0, rxout}, 32'h3C);

        // txempty=1: single group ack 1, 2-pulse ack 0, read group has no effect
        group("idle_1", 1, 1'b0, 1'b0, 208);
        group("idle_2", 2, 1'b0, 1'b0, 208);
        group("idle_rd", 3, 1'b0, 1'b0, 208);
        chk("idle_rd/txempty", {31'd0, txempty}, 32'd1);
        group("idle_1b", 1, 1'b0, 1'b0, 208);
        group("idle_1c", 1, 1'b0, 1'b0, 208);

        // Reset mid-byte (4 bits in), mid-pulse, with a tx byte pending
        txin    = 8'h77;
        txstart = 1'b1;
        @(negedge refclk);
        txstart = 1'b0;
        chk("rst2/txempty_pre", {31'd0, txempty}, 32'd0);
        testreq = 1'b1;
        repeat (5) @(negedge refclk);
        chk("rst2/ack_pre", {31'd0, testack}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst2/testack", {31'd0, testack}, 32'd0);
        chk("rst2/rxout",   {24'd0, rxout},   32'h00);
        chk("rst2/rxfull",  {31'd0, rxfull},  32'd0);
        chk("rst2/txempty", {31'd0, txempty}, 32'd1);
        testreq = 1'b0;
        repeat (3) @(negedge refclk);
        rst_n = 1'b1;
        repeat (3) @(negedge refclk);
        send_byte("rx5A", 8'h5A, 1'b0, 8'h5A);

        // Gap boundary: GAP-1 low cycles merges, GAP low cycles separates
        pulse("gap_m1", 1'b1, GAP - 1);
        pulse("gap_m2", 1'b0, 208);
        pulse("gap_s1", 1'b1, GAP);
        pulse("gap_s2", 1'b1, 208);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
